// File: rtl/exception_ctrl_if.sv
// Groups the pipeline-side signals of the exception controller.
// The pipeline drives causes through the master modport; the controller answers through the slave modport.
interface exception_ctrl_if #(
    parameter int NUM_IRQ = 4
);
    logic               overflow;
    logic [31:0]        ex_pc;
    logic               undef_op;
    logic               eret;
    logic               id_valid;
    logic [31:0]        id_pc;
    logic [NUM_IRQ-1:0] irq;
    logic [NUM_IRQ-1:0] irq_mask;
    logic               Exception;
    logic               IF_Flush;
    logic               ID_Flush;
    logic               EX_Flush;
    logic               PC_Redirect;
    logic [31:0]        RedirectPC;
    logic [31:0]        EPC;
    logic [31:0]        Cause;
    logic               in_handler;

    // There is no valid/ready handshake: every cause is level-qualified, and the controller responds
    // in the same cycle through its flush/redirect outputs.
    modport master (
        output overflow, ex_pc, undef_op, eret, id_valid, id_pc, irq, irq_mask,
        input  Exception, IF_Flush, ID_Flush, EX_Flush, PC_Redirect, RedirectPC, EPC, Cause, in_handler
    );

    modport slave (
        input  overflow, ex_pc, undef_op, eret, id_valid, id_pc, irq, irq_mask,
        output Exception, IF_Flush, ID_Flush, EX_Flush, PC_Redirect, RedirectPC, EPC, Cause, in_handler
    );
endinterface

// File: rtl/exception_ctrl.sv
// Exception/interrupt entry and ERET return sequencing for the 5-stage pipeline.
// Holds EPC/Cause and drives the flush + PC redirect outputs combinationally.
module exception_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0080,
    parameter int          NUM_IRQ      = 4
) (
    input  logic             clk,
    input  logic             rst,
    exception_ctrl_if.slave  bus,
    output logic             o_dbg_state
);
    typedef enum logic { S_RUN = 1'b0, S_HANDLER = 1'b1 } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [31:0]        r_epc;
    logic [4:0]         r_exc;
    logic               r_nested;
    logic [NUM_IRQ-1:0] r_irq;

    logic               w_irq_pend;
    logic               w_take;
    logic [31:0]        w_epc_d;
    logic [4:0]         w_exc_d;
    logic               w_set_nested;
    logic               w_clr_nested;
    logic [31:0]        w_cause;

    assign w_irq_pend = |(bus.irq & bus.irq_mask);

    always_comb begin
        w_next          = r_state;
        w_take          = 1'b0;
        w_epc_d         = r_epc;
        w_exc_d         = r_exc;
        w_set_nested    = 1'b0;
        w_clr_nested    = 1'b0;
        bus.Exception   = 1'b0;
        bus.IF_Flush    = 1'b0;
        bus.ID_Flush    = 1'b0;
        bus.EX_Flush    = 1'b0;
        bus.PC_Redirect = 1'b0;
        bus.RedirectPC  = 32'h0;
        if (!rst) begin
            unique case (r_state)
                S_RUN: begin
                    if (bus.overflow) begin
                        w_take       = 1'b1;
                        bus.EX_Flush = 1'b1;
                        w_epc_d      = bus.ex_pc;
                        w_exc_d      = 5'd12;
                    end else if (bus.id_valid && (bus.undef_op || bus.eret)) begin
                        w_take  = 1'b1;
                        w_epc_d = bus.id_pc;
                        w_exc_d = 5'd10;
                    end else if (bus.id_valid && w_irq_pend) begin
                        // EPC points at the ID instruction so it re-executes after return
                        w_take  = 1'b1;
                        w_epc_d = bus.id_pc;
                        w_exc_d = 5'd0;
                    end
                    if (w_take) begin
                        bus.Exception   = 1'b1;
                        bus.IF_Flush    = 1'b1;
                        bus.ID_Flush    = 1'b1;
                        bus.PC_Redirect = 1'b1;
                        bus.RedirectPC  = HANDLER_ADDR;
                        w_next          = S_HANDLER;
                    end
                end
                S_HANDLER: begin
                    // Nested overflow only suppresses writeback; EPC/ExcCode keep the first cause
                    if (bus.overflow) begin
                        bus.EX_Flush = 1'b1;
                        w_set_nested = 1'b1;
                    end
                    if (bus.eret && bus.id_valid) begin
                        bus.IF_Flush    = 1'b1;
                        bus.PC_Redirect = 1'b1;
                        bus.RedirectPC  = r_epc;
                        w_clr_nested    = 1'b1;
                        w_next          = S_RUN;
                    end
                end
                default: w_next = S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_RUN;
            r_epc    <= 32'h0;
            r_exc    <= 5'd0;
            r_nested <= 1'b0;
            r_irq    <= '0;
        end else begin
            r_state <= w_next;
            r_irq   <= bus.irq;
            if (w_take) begin
                r_epc <= w_epc_d;
                r_exc <= w_exc_d;
            end
            if (w_clr_nested) begin
                r_nested <= 1'b0;
            end else if (w_set_nested) begin
                r_nested <= 1'b1;
            end
        end
    end

    always_comb begin
        w_cause                = 32'h0;
        w_cause[31]            = r_nested;
        w_cause[8 +: NUM_IRQ]  = r_irq;
        w_cause[6:2]           = r_exc;
    end

    assign bus.EPC        = rst ? 32'h0 : r_epc;
    assign bus.Cause      = rst ? 32'h0 : w_cause;
    assign bus.in_handler = !rst && (r_state == S_HANDLER);
    assign o_dbg_state    = r_state;
endmodule
